uart_byte_packer: RTL

Packs the byte stream from the UART receiver (one `data`/`done` pulse per received byte) into OUT_WIDTH-bit words and writes them into the write side of the downstream async FIFO. Sits between the UART RX stage and the async FIFO on the UART clock domain. Provides two words of buffering against FIFO back-pressure, a padded flush of partial words, and sticky overflow accounting for bytes that cannot be stored.

---
 rtl/uart_byte_packer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_byte_packer.sv
// rtl/uart_byte_packer.sv - packs UART RX bytes into little-endian words for the async FIFO
module uart_byte_packer #(
  parameter int                  IN_WIDTH  = 8,
  parameter int                  OUT_WIDTH = 32,
  parameter logic [IN_WIDTH-1:0] PAD_BYTE  = '0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [IN_WIDTH-1:0]                      in_data,
  input  logic                                     in_valid,
  input  logic                                     flush,
  input  logic                                     fifo_full,
  output logic                                     fifo_wr_en,
  output logic [OUT_WIDTH-1:0]                     fifo_wr_data,
  output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]      byte_cnt,
  output logic                                     overflow,
  input  logic                                     clr_overflow,
  output logic [15:0]                              drop_count
);

  localparam int NB = OUT_WIDTH / IN_WIDTH;
  localparam int CW = $clog2(NB) + 1;

  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic [OUT_WIDTH-1:0]   acc_fill;
  logic [OUT_WIDTH-1:0]   word_fill;
  logic [CW-1:0]          cnt_fill;
  logic                   complete;
  logic                   pend_free;
  logic                   transfer;
  logic                   drop;

  assign fifo_wr_en   = pend_valid_q & ~fifo_full;
  assign fifo_wr_data = pend_data_q;
  assign byte_cnt     = cnt_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_cnt_q;

  // Merge the incoming byte into its lane and, on flush, pad the unused lanes.
  always_comb begin
    acc_fill = acc_q;
    for (int k = 0; k < NB; k++) begin
      if ((state_q == S_FILL) && in_valid && (cnt_q == CW'(k))) begin
        acc_fill[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
    cnt_fill  = cnt_q + {{(CW-1){1'b0}}, in_valid};
    word_fill = acc_fill;
    if (flush) begin
      for (int k = 0; k < NB; k++) begin
        if (CW'(k) >= cnt_fill) begin
          word_fill[k*IN_WIDTH +: IN_WIDTH] = PAD_BYTE;
        end
      end
    end
    complete  = (state_q == S_FILL) &&
                ((cnt_fill == CW'(NB)) || (flush && (cnt_fill != '0)));
    // A write this cycle vacates the pending slot, so it can be refilled at once.
    pend_free = ~pend_valid_q | fifo_wr_en;
    transfer  = pend_free && (complete || (state_q == S_HOLD));
    drop      = (state_q == S_HOLD) && in_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: park a completed word in HOLD until the pending slot frees up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: if (complete && !pend_free) state_d = S_HOLD;
      S_HOLD: if (pend_free)              state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Datapath next values: accumulator, pending register and drop accounting.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q & ~fifo_wr_en;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;

    if (transfer) begin
      pend_data_d  = (state_q == S_HOLD) ? acc_q : word_fill;
      pend_valid_d = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
    end else if (state_q == S_FILL) begin
      if (complete) begin
        acc_d = word_fill;
        cnt_d = CW'(NB);
      end else begin
        acc_d = acc_fill;
        cnt_d = cnt_fill;
      end
    end

    // Clearing wins over a drop in the same cycle.
    if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Datapath registers; reset discards partial and pending words.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule
